// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the two-requester asynchronous SRAM controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_port_arbiter_pkg;

    // Access sequencer phases; the encodings are also what a logic analyser sees on state_q.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Requester indices: 0 is the host PIO path, 1 is the on-chip test engine.
    localparam int REQ_HOST = 0;
    localparam int REQ_TEST = 1;

    // Legal range of the ACCESS-phase length and the width of its down-counter.
    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

    // Index of the set bit in a one-hot pair (a zero vector maps to requester 0).
    function automatic logic onehot2_idx(input logic [1:0] oh);
        return oh[REQ_TEST];
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered priority pointer.
// Latency: grant is combinational from req_i; pointer moves on the edge where advance_i is high.
// Backpressure: none; the caller only asserts advance_i when it actually consumes the grant.
//
// Ports:
//   clk, reset_n  clock and async active-low reset
//   req_i[1:0]    request vector
//   advance_i     grant consumed this cycle; pointer moves past the winner
//   grant_o[1:0]  one-hot winner (zero when nobody requests)
//   ptr_o         requester that wins a tie (0 after reset)
module rr_arbiter2
    import sram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       ptr_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o[REQ_HOST] = 1'b1;
            2'b10:   grant_o[REQ_TEST] = 1'b1;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    // The requester that just won loses the next tie.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (grant_o != 2'b00)) begin
            ptr_d = ~onehot2_idx(grant_o);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin two-requester controller for a single-port asynchronous SRAM with registered pad strobes.
// Latency: gnt one cycle after req is seen in IDLE; done exactly WAIT_CYCLES+2 cycles after gnt.
// Backpressure: req is held until gnt; while busy, further requests simply wait (no queueing).
//
// Ports:
//   clk, reset_n              clock and async active-low reset (aborts any access in flight)
//   req_i/we_i[1:0]           per-requester request and direction (1 = write)
//   addr0_i/addr1_i           per-requester address, latched when the grant is issued
//   wdata0_i/wdata1_i         per-requester write data, latched when the grant is issued
//   gnt_o/done_o[1:0]         one-hot single-cycle grant and completion pulses
//   rdata_o                   last read data, updated on the final ACCESS edge of a read
//   busy_o                    high whenever the sequencer is outside IDLE
//   sram_*                    address, data-out, drive enable, data-in and active-low strobes
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_dq_out_o,
    output logic              sram_dq_oe_o,
    input  logic [DATA_W-1:0] sram_dq_in_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    generate
        if ((WAIT_CYCLES < WAIT_MIN) || (WAIT_CYCLES > WAIT_MAX)) begin : g_bad_wait
            $error("sram_port_arbiter: WAIT_CYCLES out of range 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    // Sequencer state and latched request.
    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               owner_q,     owner_d;
    logic               op_we_q,     op_we_d;
    logic [ADDR_W-1:0]  op_addr_q,   op_addr_d;
    logic [DATA_W-1:0]  op_wdata_q,  op_wdata_d;

    // Registered outputs.
    logic [1:0]         gnt_q,       gnt_d;
    logic [1:0]         done_q,      done_d;
    logic [DATA_W-1:0]  rdata_q,     rdata_d;
    logic               busy_q,      busy_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [DATA_W-1:0]  dq_out_q,    dq_out_d;
    logic               dq_oe_q,     dq_oe_d;
    logic               ce_n_q,      ce_n_d;
    logic               oe_n_q,      oe_n_d;
    logic               we_n_q,      we_n_d;

    logic [1:0]         arb_gnt;
    logic               arb_ptr;
    logic               arb_advance;
    logic               grant_window;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req_i),
        .advance_i (arb_advance),
        .grant_o   (arb_gnt),
        .ptr_o     (arb_ptr)
    );

    // Next-state logic. The gnt pulse occupies an IDLE cycle: gnt_q being set while in
    // IDLE marks "granted, launch SETUP next", so a new decision is only taken in IDLE
    // with no grant pending, or on the DONE cycle (making the following IDLE the grant cycle).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        op_we_d      = op_we_q;
        op_addr_d    = op_addr_q;
        op_wdata_d   = op_wdata_q;
        gnt_d        = 2'b00;
        done_d       = 2'b00;
        rdata_d      = rdata_q;
        arb_advance  = 1'b0;
        grant_window = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_q != 2'b00) begin
                    state_d = ST_SETUP;
                end else begin
                    grant_window = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = CNT_LOAD;
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d         = ST_DONE;
                    done_d[owner_q] = 1'b1;
                    if (!op_we_q) begin
                        rdata_d = sram_dq_in_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                grant_window = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_window && (arb_gnt != 2'b00)) begin
            gnt_d       = arb_gnt;
            arb_advance = 1'b1;
            owner_d     = onehot2_idx(arb_gnt);
            if (onehot2_idx(arb_gnt)) begin
                op_we_d    = we_i[REQ_TEST];
                op_addr_d  = addr1_i;
                op_wdata_d = wdata1_i;
            end else begin
                op_we_d    = we_i[REQ_HOST];
                op_addr_d  = addr0_i;
                op_wdata_d = wdata0_i;
            end
        end
    end

    // Pad strobes for the coming cycle, derived from the phase being entered so every
    // pin leaves a flop. Write data is driven from SETUP through DONE to cover setup and
    // hold around the we_n pulse; reads never drive DQ.
    always_comb begin
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        busy_d   = (state_d != ST_IDLE);

        unique case (state_d)
            ST_SETUP: begin
                ce_n_d = 1'b0;
                addr_d = op_addr_q;
                if (op_we_q) begin
                    dq_oe_d  = 1'b1;
                    dq_out_d = op_wdata_q;
                end else begin
                    oe_n_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                ce_n_d = 1'b0;
                if (op_we_q) begin
                    dq_oe_d = 1'b1;
                    we_n_d  = 1'b0;
                end else begin
                    oe_n_d = 1'b0;
                end
            end
            ST_DONE: begin
                ce_n_d  = 1'b0;
                dq_oe_d = op_we_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            op_we_q    <= 1'b0;
            op_addr_q  <= '0;
            op_wdata_q <= '0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            op_we_q    <= op_we_d;
            op_addr_q  <= op_addr_d;
            op_wdata_q <= op_wdata_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign done_o        = done_q;
    assign rdata_o       = rdata_q;
    assign busy_o        = busy_q;
    assign sram_addr_o   = addr_q;
    assign sram_dq_out_o = dq_out_q;
    assign sram_dq_oe_o  = dq_oe_q;
    assign sram_ce_n_o   = ce_n_q;
    assign sram_oe_n_o   = oe_n_q;
    assign sram_we_n_o   = we_n_q;

    // A tie must always go to the pointed-at requester.
    a_tie_follows_ptr: assert property (@(posedge clk) disable iff (!reset_n)
        (req_i == 2'b11) |-> arb_gnt[arb_ptr]);
    // DQ is never driven while the SRAM drives it, and we_n never pulses without ce_n.
    a_no_contention: assert property (@(posedge clk) disable iff (!reset_n)
        !(dq_oe_q && !oe_n_q) && !(!we_n_q && ce_n_q));

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    req, we, gnt, done;
    logic [AW-1:0] addr0, addr1, sram_addr;
    logic [DW-1:0] wdata0, wdata1, rdata, dq_out, dq_in;
    logic          busy, dq_oe, ce_n, oe_n, we_n;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .busy_o(busy),
        .sram_addr_o(sram_addr), .sram_dq_out_o(dq_out), .sram_dq_oe_o(dq_oe),
        .sram_dq_in_i(dq_in), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n)
    );

    // Pin-level SRAM model and an independent transaction-level reference memory.
    logic [DW-1:0] sram_mem [2048];
    logic [DW-1:0] ref_mem  [2048];
    assign dq_in = (!ce_n && !oe_n) ? sram_mem[sram_addr] : 8'h00;
    always @(posedge clk) if (!ce_n && !we_n && dq_oe) sram_mem[sram_addr] <= dq_out;

    typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
    typedef struct {bit port; bit w; logic [DW-1:0] d; int cyc;} exp_t;
    op_t  q0[$], q1[$];
    exp_t sb[$];
    int   gnt_cyc_log[$];
    bit   gnt_port_log[$];
    int   n_chk = 0, n_err = 0, cyc = 0, we_low = 0, done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_op(input bit p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.w = w; o.a = a; o.d = d;
        if (p) q1.push_back(o); else q0.push_back(o);
    endtask

    // Requester agents + scoreboard: expectations pushed at grant, popped at done.
    always @(negedge clk) begin : mon
        op_t  o;
        exp_t e;
        bit   p;
        cyc++;
        if (reset_n) begin
            chk("no_contention", {30'd0, dq_oe && !oe_n, !we_n && ce_n}, 0);
            if (!we_n) we_low++;
            if (gnt != 2'b00) begin
                chk("gnt_onehot", 32'($onehot(gnt)), 1);
                p = gnt[1];
                gnt_cyc_log.push_back(cyc);
                gnt_port_log.push_back(p);
                if ((p && q1.size() == 0) || (!p && q0.size() == 0)) begin
                    chk("gnt_without_req", 32'(gnt), 0);
                end else begin
                    if (p) o = q1.pop_front(); else o = q0.pop_front();
                    e.port = p; e.w = o.w; e.cyc = cyc;
                    if (o.w) begin
                        ref_mem[o.a] = o.d;
                        e.d = o.d;
                    end else begin
                        e.d = ref_mem[o.a];
                    end
                    sb.push_back(e);
                end
            end
            if (done != 2'b00) begin
                done_cnt++;
                chk("done_onehot", 32'($onehot(done)), 1);
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done), 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_port", 32'(done[1]), 32'(e.port));
                    chk("done_latency", cyc - e.cyc, WC + 2);
                    if (e.w) chk("we_n_low_cycles", we_low, WC);
                    else     chk("rdata", 32'(rdata), 32'(e.d));
                end
                we_low = 0;
            end
        end
        req[0] = (q0.size() != 0);
        req[1] = (q1.size() != 0);
        if (q0.size() != 0) begin we[0] = q0[0].w; addr0 = q0[0].a; wdata0 = q0[0].d; end
        if (q1.size() != 0) begin we[1] = q1[0].w; addr1 = q1[0].a; wdata1 = q1[0].d; end
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(q0.size() + q1.size() + sb.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_order4 [5];
        int n;
        int dc;
        exp_order4 = '{1, 1, 1, 0, 1};
        for (int i = 0; i < 2048; i++) begin
            sram_mem[i] = 8'(i * 7 + 3);
            ref_mem[i]  = 8'(i * 7 + 3);
        end
        reset_n = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // 1: reset holds everything quiet even with both requests high.
        push_op(0, 0, 11'h010, 8'h00);
        push_op(1, 0, 11'h020, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_seen", 32'(req), 2'b11);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_strobes", {29'd0, ce_n, oe_n, we_n}, 3'b111);
        chk("rst_dq_oe", 32'(dq_oe), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        reset_n = 1'b1;
        wait_drain(100);
        chk("t1_gnt_count", gnt_port_log.size(), 2);
        if (gnt_port_log.size() == 2) begin
            chk("t1_first_is_0", 32'(gnt_port_log[0]), 0);
            chk("t1_second_is_1", 32'(gnt_port_log[1]), 1);
        end

        // 2: write then read back through the same port, then via the other port.
        push_op(0, 1, 11'h055, 8'hA5);
        push_op(0, 0, 11'h055, 8'h00);
        wait_drain(100);
        chk("t2_rdata_p0", 32'(rdata), 8'hA5);
        chk("t2_sram_cell", 32'(sram_mem[11'h055]), 8'hA5);
        push_op(1, 0, 11'h055, 8'h00);
        wait_drain(100);
        chk("t2_rdata_p1", 32'(rdata), 8'hA5);

        // 3: both requesters saturating: strict alternation, 5-cycle grant spacing.
        gnt_cyc_log.delete(); gnt_port_log.delete();
        push_op(0, 1, 11'h100, 8'h11); push_op(1, 1, 11'h101, 8'h22);
        push_op(0, 0, 11'h100, 8'h00); push_op(1, 0, 11'h101, 8'h00);
        push_op(0, 0, 11'h200, 8'h00); push_op(1, 0, 11'h100, 8'h00);
        wait_drain(300);
        chk("t3_gnt_count", gnt_port_log.size(), 6);
        if (gnt_port_log.size() == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("t3_order_%0d", i), 32'(gnt_port_log[i]), i % 2);
            for (int i = 1; i < 6; i++) chk($sformatf("t3_spacing_%0d", i), gnt_cyc_log[i] - gnt_cyc_log[i-1], WC + 3);
        end

        // 4: requester 1 streaming; requester 0 joins and wins the next tie.
        gnt_cyc_log.delete(); gnt_port_log.delete();
        for (int i = 0; i < 4; i++) push_op(1, 0, 11'(11'h300 + i), 8'h00);
        n = 0;
        while (gnt_port_log.size() < 3 && n < 100) begin @(posedge clk); n++; end
        chk("t4_three_grants_in_budget", 32'(gnt_port_log.size() >= 3), 1);
        push_op(0, 0, 11'h055, 8'h00);
        wait_drain(200);
        chk("t4_gnt_count", gnt_port_log.size(), 5);
        if (gnt_port_log.size() == 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("t4_order_%0d", i), 32'(gnt_port_log[i]), 32'(exp_order4[i]));
        end

        // 5: reset during the write pulse aborts it with no done.
        push_op(0, 1, 11'h123, 8'h3C);
        n = 0;
        while (n < 50) begin
            @(posedge clk); #1;
            n++;
            if (!we_n) break;
        end
        chk("t5_reached_access", 32'(we_n), 0);
        dc = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("t5_we_n_async", 32'(we_n), 1);
        chk("t5_ce_n_async", 32'(ce_n), 1);
        chk("t5_dq_oe_async", 32'(dq_oe), 0);
        chk("t5_busy_async", 32'(busy), 0);
        sb.delete();
        we_low = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt - dc, 0);
        gnt_cyc_log.delete(); gnt_port_log.delete();
        push_op(1, 0, 11'h200, 8'h00);
        push_op(0, 0, 11'h055, 8'h00);
        wait_drain(100);
        chk("t5_gnt_count", gnt_port_log.size(), 2);
        if (gnt_port_log.size() == 2) chk("t5_host_first", 32'(gnt_port_log[0]), 0);
        chk("t5_rdata_last", 32'(rdata), 32'(ref_mem[11'h200]));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
